l1_refill_ctrl: RTL and testbench

L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

---
 rtl/l1_refill_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_l1_refill_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_refill_ctrl.sv
// Purpose : L1 line-refill controller; arbitrates inst/data misses and streams one burst line into the owner's memory.
// Latency : req to done pulse = 1 (grant) + AR handshake + READ_BURST_LEN beats + 1 (done) cycles.
// Backpr. : holds mem_ar_* until mem_ar_ready; always ready for read beats, so gaps in mem_r_valid just stall.
//
// Ports:
//   cpu_clk / cpu_rst_n                     clock, async active-low reset
//   inst_miss_req/addr, inst_refill_done    instruction-side miss request and completion pulse
//   data_miss_req/addr, data_refill_done    data-side miss request and completion pulse
//   mem_ar_valid/ready/addr                 burst read request to the memory side
//   mem_r_valid/data                        read beats returned by the memory side
//   dma_inst_mem_waddr/wdata, inst_mem_write   instruction memory write port
//   dma_data_mem_waddr/wdata, data_mem_write   data memory write port
//   data_mem_write_ctrl_by                  1 while a data-owned refill holds the data memory port
//   refill_busy                             a refill is in flight
module l1_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_BURST_LEN = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  inst_miss_req,
    input  logic [ADDR_WIDTH-1:0] inst_miss_addr,
    output logic                  inst_refill_done,
    input  logic                  data_miss_req,
    input  logic [ADDR_WIDTH-1:0] data_miss_addr,
    output logic                  data_refill_done,
    output logic                  mem_ar_valid,
    input  logic                  mem_ar_ready,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr,
    input  logic                  mem_r_valid,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_WIDTH-1:0] dma_inst_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_inst_mem_wdata,
    output logic                  inst_mem_write,
    output logic [ADDR_WIDTH-1:0] dma_data_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_data_mem_wdata,
    output logic                  data_mem_write,
    output logic                  data_mem_write_ctrl_by,
    output logic                  refill_busy
);

    localparam int BEAT_W = $clog2(READ_BURST_LEN);
    // Line offset in bytes: words are addressed 4 bytes apart.
    localparam int OFF_W  = $clog2(READ_BURST_LEN * 4);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(READ_BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t                r_state;
    state_t                w_state_nxt;
    owner_t                r_owner;
    owner_t                r_prio;
    owner_t                w_winner;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [BEAT_W-1:0]     r_beat;
    logic                  w_grant;
    logic                  w_beat_acc;
    logic                  w_contested;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and all outputs; every output idles at 0 so reset (which
    // forces IDLE asynchronously) drives the whole interface to 0 at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt            = r_state;
        w_grant                = 1'b0;
        w_beat_acc             = 1'b0;
        w_contested            = inst_miss_req && data_miss_req;
        w_winner               = OWN_INST;
        w_beat_addr            = r_base + ADDR_WIDTH'({r_beat, 2'b00});
        inst_refill_done       = 1'b0;
        data_refill_done       = 1'b0;
        mem_ar_valid           = 1'b0;
        mem_ar_addr            = '0;
        dma_inst_mem_waddr     = '0;
        dma_inst_mem_wdata     = '0;
        inst_mem_write         = 1'b0;
        dma_data_mem_waddr     = '0;
        dma_data_mem_wdata     = '0;
        data_mem_write         = 1'b0;
        data_mem_write_ctrl_by = 1'b0;
        refill_busy            = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (inst_miss_req || data_miss_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ADDR;
                    if (w_contested) begin
                        w_winner = r_prio;
                    end else if (data_miss_req) begin
                        w_winner = OWN_DATA;
                    end else begin
                        w_winner = OWN_INST;
                    end
                end
            end

            ST_ADDR: begin
                mem_ar_valid           = 1'b1;
                mem_ar_addr            = r_base;
                data_mem_write_ctrl_by = (r_owner == OWN_DATA);
                if (mem_ar_ready) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                data_mem_write_ctrl_by = (r_owner == OWN_DATA);
                if (mem_r_valid) begin
                    w_beat_acc = 1'b1;
                    if (r_owner == OWN_INST) begin
                        inst_mem_write     = 1'b1;
                        dma_inst_mem_waddr = w_beat_addr;
                        dma_inst_mem_wdata = mem_r_data;
                    end else begin
                        data_mem_write     = 1'b1;
                        dma_data_mem_waddr = w_beat_addr;
                        dma_data_mem_wdata = mem_r_data;
                    end
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                data_mem_write_ctrl_by = (r_owner == OWN_DATA);
                inst_refill_done       = (r_owner == OWN_INST);
                data_refill_done       = (r_owner == OWN_DATA);
                w_state_nxt            = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Refill context: owner, line base, beat counter, round-robin flag.
    // The flag only moves on a contested grant, so an uncontested grant
    // never steals the next turn from the side that just lost.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_owner <= OWN_INST;
            r_prio  <= OWN_INST;
            r_base  <= '0;
            r_beat  <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_winner;
                r_base  <= ((w_winner == OWN_DATA) ? data_miss_addr : inst_miss_addr) & LINE_MASK;
                if (w_contested) begin
                    r_prio <= (w_winner == OWN_INST) ? OWN_DATA : OWN_INST;
                end
            end
            if ((r_state == ST_ADDR) && mem_ar_ready) begin
                r_beat <= '0;
            end else if (w_beat_acc) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
module tb_l1_refill_ctrl;

    localparam int          BL        = 8;
    localparam logic [31:0] LINE_MASK = ~(32'(BL * 4) - 32'd1);

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        inst_miss_req;
    logic [31:0] inst_miss_addr;
    logic        inst_refill_done;
    logic        data_miss_req;
    logic [31:0] data_miss_addr;
    logic        data_refill_done;
    logic        mem_ar_valid;
    logic        mem_ar_ready;
    logic [31:0] mem_ar_addr;
    logic        mem_r_valid;
    logic [31:0] mem_r_data;
    logic [31:0] dma_inst_mem_waddr;
    logic [31:0] dma_inst_mem_wdata;
    logic        inst_mem_write;
    logic [31:0] dma_data_mem_waddr;
    logic [31:0] dma_data_mem_wdata;
    logic        data_mem_write;
    logic        data_mem_write_ctrl_by;
    logic        refill_busy;

    l1_refill_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .READ_BURST_LEN (BL)
    ) dut (
        .cpu_clk                (cpu_clk),
        .cpu_rst_n              (cpu_rst_n),
        .inst_miss_req          (inst_miss_req),
        .inst_miss_addr         (inst_miss_addr),
        .inst_refill_done       (inst_refill_done),
        .data_miss_req          (data_miss_req),
        .data_miss_addr         (data_miss_addr),
        .data_refill_done       (data_refill_done),
        .mem_ar_valid           (mem_ar_valid),
        .mem_ar_ready           (mem_ar_ready),
        .mem_ar_addr            (mem_ar_addr),
        .mem_r_valid            (mem_r_valid),
        .mem_r_data             (mem_r_data),
        .dma_inst_mem_waddr     (dma_inst_mem_waddr),
        .dma_inst_mem_wdata     (dma_inst_mem_wdata),
        .inst_mem_write         (inst_mem_write),
        .dma_data_mem_waddr     (dma_data_mem_waddr),
        .dma_data_mem_wdata     (dma_data_mem_wdata),
        .data_mem_write         (data_mem_write),
        .data_mem_write_ctrl_by (data_mem_write_ctrl_by),
        .refill_busy            (refill_busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: one outstanding refill described by its owner, line
    // base, whether the read request is still waiting, beats written so far
    // and whether the completion pulse is due. Index 0 = inst, 1 = data.
    int          m_busy, m_ar_pend, m_done_due, m_beats, m_owner, m_prio;
    logic [31:0] m_base;
    int          cyc, m_grant_cyc, last_lat, n_done;
    int          grant_log[$];
    bit          done_seen[2];
    bit          wrote[2];

    // Requesters
    logic        rq[2];
    logic [31:0] ad[2];
    int          dly[2];

    task automatic model_reset();
        m_busy = 0; m_ar_pend = 0; m_done_due = 0; m_beats = 0; m_owner = 0; m_prio = 0;
        m_base = '0;
        for (int j = 0; j < 2; j++) begin
            done_seen[j] = 1'b0;
            wrote[j]     = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          e_arv, e_wr, e_iw, e_dw;
        logic [31:0] e_waddr;
        e_arv   = (m_busy != 0) && (m_ar_pend != 0);
        e_wr    = (m_busy != 0) && (m_ar_pend == 0) && (m_done_due == 0) && mem_r_valid;
        e_iw    = e_wr && (m_owner == 0);
        e_dw    = e_wr && (m_owner == 1);
        e_waddr = m_base + 32'(4 * m_beats);
        chk("busy",       64'(refill_busy),            64'(m_busy != 0));
        chk("ar_valid",   64'(mem_ar_valid),           64'(e_arv));
        chk("ar_addr",    64'(mem_ar_addr),            64'(e_arv ? m_base : 32'h0));
        chk("inst_we",    64'(inst_mem_write),         64'(e_iw));
        chk("inst_waddr", 64'(dma_inst_mem_waddr),     64'(e_iw ? e_waddr : 32'h0));
        chk("inst_wdata", 64'(dma_inst_mem_wdata),     64'(e_iw ? mem_r_data : 32'h0));
        chk("data_we",    64'(data_mem_write),         64'(e_dw));
        chk("data_waddr", 64'(dma_data_mem_waddr),     64'(e_dw ? e_waddr : 32'h0));
        chk("data_wdata", 64'(dma_data_mem_wdata),     64'(e_dw ? mem_r_data : 32'h0));
        chk("ctrl_by",    64'(data_mem_write_ctrl_by), 64'((m_busy != 0) && (m_owner == 1)));
        chk("inst_done",  64'(inst_refill_done),       64'((m_done_due != 0) && (m_owner == 0)));
        chk("data_done",  64'(data_refill_done),       64'((m_done_due != 0) && (m_owner == 1)));

        if (m_busy == 0) begin
            if (inst_miss_req || data_miss_req) begin
                if (inst_miss_req && data_miss_req) begin
                    m_owner = m_prio;
                    m_prio  = 1 - m_owner;
                end else begin
                    m_owner = data_miss_req ? 1 : 0;
                end
                m_base      = ((m_owner == 1) ? data_miss_addr : inst_miss_addr) & LINE_MASK;
                m_busy      = 1;
                m_ar_pend   = 1;
                m_beats     = 0;
                m_done_due  = 0;
                m_grant_cyc = cyc;
                grant_log.push_back(m_owner);
            end
        end else if (m_ar_pend != 0) begin
            if (mem_ar_ready) m_ar_pend = 0;
        end else if (m_done_due != 0) begin
            m_busy     = 0;
            m_done_due = 0;
            done_seen[m_owner] = 1'b1;
            n_done++;
            last_lat = cyc - m_grant_cyc + 1;
        end else if (mem_r_valid) begin
            wrote[m_owner] = 1'b1;
            m_beats++;
            if (m_beats == BL) m_done_due = 1;
        end
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] agg;
        agg = {19'h0, inst_refill_done, data_refill_done, mem_ar_valid, inst_mem_write,
               data_mem_write, data_mem_write_ctrl_by, refill_busy, 6'h0};
        chk({tag, "_ctl"},   64'(agg), 64'h0);
        chk({tag, "_araddr"}, 64'(mem_ar_addr), 64'h0);
        chk({tag, "_iw"},     64'({dma_inst_mem_waddr, dma_inst_mem_wdata}), 64'h0);
        chk({tag, "_dw"},     64'({dma_data_mem_waddr, dma_data_mem_wdata}), 64'h0);
    endtask

    // Requesters hold their request until they see their done pulse, drop it on
    // the following edge, then re-request after a random gap with a new address.
    // Once their own line is being written they may scribble on their address.
    task automatic drive_random();
        for (int j = 0; j < 2; j++) begin
            if (rq[j] && done_seen[j]) begin
                rq[j]        = 1'b0;
                done_seen[j] = 1'b0;
                dly[j]       = $urandom_range(0, 4);
            end else if (!rq[j]) begin
                if (dly[j] == 0) begin
                    rq[j] = 1'b1;
                    ad[j] = $urandom;
                end else begin
                    dly[j]--;
                end
            end else if (wrote[j] && ($urandom_range(0, 3) == 0)) begin
                ad[j] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF00 : $urandom;
            end
            wrote[j] = 1'b0;
        end
        inst_miss_req  = rq[0];
        inst_miss_addr = ad[0];
        data_miss_req  = rq[1];
        data_miss_addr = ad[1];
        mem_ar_ready   = ($urandom_range(0, 2) != 0);
        mem_r_valid    = ($urandom_range(0, 3) != 0);
        mem_r_data     = $urandom;
    endtask

    int          gl0, n_done_base, n_done_at_rst;
    bit          rst_injected, finished;
    logic [31:0] ar_seen;

    initial begin
        cpu_rst_n      = 1'b0;
        inst_miss_req  = 1'b0;
        inst_miss_addr = '0;
        data_miss_req  = 1'b0;
        data_miss_addr = '0;
        mem_ar_ready   = 1'b0;
        mem_r_valid    = 1'b0;
        mem_r_data     = '0;
        cyc = 0; last_lat = 0; n_done = 0; m_grant_cyc = 0;
        for (int j = 0; j < 2; j++) begin
            rq[j] = 1'b0; ad[j] = '0; dly[j] = 0;
        end
        model_reset();

        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_all_zero("reset");
        @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;

        // Single inst miss at 0x124, memory at full rate.
        inst_miss_req  = 1'b1;
        inst_miss_addr = 32'h0000_0124;
        mem_ar_ready   = 1'b1;
        mem_r_valid    = 1'b1;
        mem_r_data     = $urandom;
        ar_seen        = '0;
        for (int c = 0; c < 30 && !done_seen[0]; c++) begin
            @(negedge cpu_clk);
            if (mem_ar_valid) ar_seen = mem_ar_addr;
            model_step();
            @(posedge cpu_clk);
            #1;
            mem_r_data = $urandom;
            if (done_seen[0]) inst_miss_req = 1'b0;
        end
        chk("single_done", 64'(done_seen[0]), 64'h1);
        chk("single_lat",  64'(last_lat),     64'd11);
        chk("single_ar",   64'(ar_seen),      64'h120);

        // Reset again so both requesters start together against a fresh arbiter.
        cpu_rst_n     = 1'b0;
        inst_miss_req = 1'b0;
        mem_ar_ready  = 1'b0;
        mem_r_valid   = 1'b0;
        #1 check_all_zero("reset2");
        model_reset();
        @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;

        gl0          = grant_log.size();
        n_done_base  = n_done;
        rst_injected = 1'b0;
        finished     = 1'b0;
        n_done_at_rst = 0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            drive_random();
            @(negedge cpu_clk);
            model_step();
            if (!rst_injected && (n_done - n_done_base >= 5) && (m_busy != 0) &&
                (m_ar_pend == 0) && (m_done_due == 0) && (m_beats == 4)) begin
                // Abandon a line after its 4th beat; outputs must clear at once.
                #1 cpu_rst_n = 1'b0;
                #1 check_all_zero("midrst");
                model_reset();
                @(negedge cpu_clk);
                check_all_zero("midrst_hold");
                @(posedge cpu_clk);
                #1 cpu_rst_n = 1'b1;
                rst_injected  = 1'b1;
                n_done_at_rst = n_done;
                continue;
            end
            finished = rst_injected && (n_done - n_done_at_rst >= 6) && (n_done - n_done_base >= 20);
            @(posedge cpu_clk);
            #1;
        end
        chk("run_complete", 64'(finished), 64'h1);
        chk("rr_count",     64'(grant_log.size() >= gl0 + 2), 64'h1);
        chk("rr_first",     64'(grant_log[gl0]),     64'd0);
        chk("rr_second",    64'(grant_log[gl0 + 1]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
